// File: rtl/schmidl_cox_frame_sync.sv
// Schmidl-Cox frame synchroniser.
// Joins the metric stream and the data stream sample by sample. After the metric crosses
// the threshold, it searches SEARCH_WIN samples for the metric peak. It then emits
// packet_length samples starting at peak + start_offset. The data passes through a
// DELAY-deep delay line, so the start offset may be negative.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clear               synchronous soft clear (mode/threshold/length/offset untouched)
//   threshold           unsigned detection threshold; 0 disables detection
//   packet_length       samples per frame, 0 behaves as 1
//   start_offset        signed peak-to-first-sample offset, floored at -(DELAY-SEARCH_WIN)
//   output_select       0/3 gated frames, 1 delayed data, 2 delayed metric (top DATA_W bits)
//   m_*                 metric stream in; i_* data stream in; o_* output stream
//   detect              one-cycle pulse per peak decision
//   peak_value          metric at the most recent peak decision
//   frame_count         completed frames, wraps
module schmidl_cox_frame_sync #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned METRIC_W   = 40,
  parameter int unsigned SEARCH_WIN = 64,
  parameter int unsigned DELAY      = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [METRIC_W-1:0] threshold,
  input  logic [CNT_W-1:0]    packet_length,
  input  logic [CNT_W-1:0]    start_offset,
  input  logic [1:0]          output_select,
  input  logic [METRIC_W-1:0] m_tdata,
  input  logic                m_tlast,
  input  logic                m_tvalid,
  output logic                m_tready,
  input  logic [DATA_W-1:0]   i_tdata,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [DATA_W-1:0]   o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic                detect,
  output logic [METRIC_W-1:0] peak_value,
  output logic [31:0]         frame_count
);

  localparam int unsigned AW     = $clog2(DELAY);
  localparam int unsigned FillW  = AW + 1;
  localparam int unsigned WinW   = $clog2(SEARCH_WIN + 1);
  localparam int unsigned EntW   = 2 * DATA_W + 1;
  // Most negative offset whose first sample is still inside the delay line at decision time.
  localparam int          MinOff = -int'(DELAY - SEARCH_WIN);

  typedef enum logic [1:0] {StIdle, StSearch, StArmed, StForward} state_e;

  state_e              state_q;
  logic                armed_q;
  logic [FillW-1:0]    fill_q;
  logic [31:0]         n_q;
  logic [METRIC_W-1:0] max_q;
  logic [31:0]         pk_q;
  logic [31:0]         start_q;
  logic [WinW-1:0]     win_q;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    cnt_q;

  // Only the top DATA_W metric bits are ever emitted, so only those are stored.
  logic [EntW-1:0]     mem [DELAY];
  logic [AW-1:0]       wptr;

  logic                adv, avail, below, gated, start_hit;
  logic                frame_emit, frame_last, emit, decide, new_peak;
  logic [DATA_W-1:0]   d_data, d_mtop, out_data;
  logic                d_last, out_last;
  logic [31:0]         d_idx, cand_pk;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [METRIC_W-1:0] cand_max;
  logic signed [31:0]  off_ext, off_sat;
  logic                unused_ok;

  assign unused_ok = m_tlast;

  assign adv      = m_tvalid & i_tvalid & (o_tready | ~o_tvalid);
  assign m_tready = adv;
  assign i_tready = adv;
  assign wptr     = n_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (adv) mem[wptr] <= {i_tdata, m_tdata[METRIC_W-1 -: DATA_W], i_tlast};
  end

  always_comb begin
    // The slot about to be overwritten holds sample n - DELAY.
    {d_data, d_mtop, d_last} = mem[wptr];
    d_idx      = n_q - 32'(DELAY);
    avail      = (fill_q == FillW'(DELAY));
    below      = (m_tdata < threshold);
    gated      = !((output_select == 2'd1) || (output_select == 2'd2));
    start_hit  = avail && (d_idx == start_q);
    frame_emit = ((state_q == StArmed) && start_hit) || ((state_q == StForward) && avail);
    cnt_nxt    = (state_q == StArmed) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    frame_last = frame_emit && (cnt_nxt == len_q);
    emit       = avail && (gated ? frame_emit : 1'b1);
    // Strictly greater only, so ties keep the earliest index.
    new_peak   = (state_q == StIdle) || (m_tdata > max_q);
    cand_max   = new_peak ? m_tdata : max_q;
    cand_pk    = new_peak ? n_q : pk_q;
    decide     = ((state_q == StIdle) && armed_q && !below && (SEARCH_WIN == 1)) ||
                 ((state_q == StSearch) && (win_q == WinW'(SEARCH_WIN - 1)));
    off_ext    = 32'($signed(start_offset));
    off_sat    = (off_ext < MinOff) ? MinOff : off_ext;
    out_data   = (output_select == 2'd2) ? d_mtop : d_data;
    out_last   = gated ? frame_last : d_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      fill_q      <= '0;
      n_q         <= '0;
      max_q       <= '0;
      pk_q        <= '0;
      start_q     <= '0;
      win_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tvalid    <= 1'b0;
      detect      <= 1'b0;
      peak_value  <= '0;
      frame_count <= '0;
    end else if (clear) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      fill_q      <= '0;
      n_q         <= '0;
      max_q       <= '0;
      pk_q        <= '0;
      start_q     <= '0;
      win_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tvalid    <= 1'b0;
      detect      <= 1'b0;
      peak_value  <= '0;
      frame_count <= '0;
    end else begin
      detect <= 1'b0;

      if (adv && emit) begin
        o_tvalid <= 1'b1;
        o_tdata  <= out_data;
        o_tlast  <= out_last;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
      end

      if (adv) begin
        n_q <= n_q + 32'd1;
        if (!avail) fill_q <= fill_q + FillW'(1);

        unique case (state_q)
          StIdle: begin
            if (below) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= StSearch;
              max_q   <= cand_max;
              pk_q    <= cand_pk;
              win_q   <= WinW'(1);
            end
          end
          StSearch: begin
            max_q <= cand_max;
            pk_q  <= cand_pk;
            win_q <= win_q + WinW'(1);
          end
          StArmed, StForward: begin
            if (frame_emit) begin
              cnt_q <= cnt_nxt;
              if (frame_last) begin
                state_q     <= StIdle;
                frame_count <= frame_count + 32'd1;
              end else begin
                state_q <= StForward;
              end
            end
          end
          default: ;
        endcase

        // Peak decision overrides the search bookkeeping above.
        if (decide) begin
          detect     <= 1'b1;
          peak_value <= cand_max;
          start_q    <= cand_pk + off_sat;
          len_q      <= (packet_length == '0) ? CNT_W'(1) : packet_length;
          armed_q    <= 1'b0;
          state_q    <= StArmed;
        end
      end
    end
  end

endmodule

// File: doc/schmidl_cox_frame_sync.md
Name: schmidl_cox_frame_sync

Overview:
Parametrised successor to the Schmidl-Cox threshold detector. It consumes sample-aligned metric and data streams from metric_calculator. After a threshold crossing it searches a fixed window for the metric peak. It then emits exactly packet_length data samples starting at the peak index plus a signed start offset, which can be negative thanks to an internal DELAY-deep data delay line. It sits between metric_calculator and the block payload output and adds hysteresis re-arming, selectable output modes and detection status.

Parameters:
DATA_W, 32, data sample width (sc16 IQ)
METRIC_W, 40, unsigned metric width; must be >= DATA_W
SEARCH_WIN, 64, peak-search window length in samples, >= 1
DELAY, 256, data delay-line depth in samples; power of 2, > SEARCH_WIN
CNT_W, 16, width of packet_length and start_offset

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous soft clear of internal state
threshold  in  METRIC_W  detection threshold, unsigned
packet_length  in  CNT_W  samples per emitted frame; 0 treated as 1
start_offset  in  CNT_W  signed offset from peak to first emitted sample
output_select  in  2  0=gated frames, 1=delayed passthrough, 2=delayed metric, 3=as 0
m_tdata/m_tlast/m_tvalid  in  METRIC_W/1/1  metric stream
m_tready  out  1  metric ready
i_tdata/i_tlast/i_tvalid  in  DATA_W/1/1  data stream
i_tready  out  1  data ready
o_tdata/o_tlast/o_tvalid  out  DATA_W/1/1  output stream
o_tready  in  1  output ready
detect  out  1  one-cycle pulse on each peak decision
peak_value  out  METRIC_W  metric at the last decided peak
frame_count  out  32  count of completed frames, wraps

Behaviour:
- Reset (asynchronous, reset_n=0): FSM=IDLE, disarmed; fill count, sample index and frame_count=0; o_tvalid=0, o_tlast=0, o_tdata=0; detect=0; peak_value=0. Outputs drop immediately, even mid-frame.
- clear=1: same state as reset on the next edge, except that the threshold, length, offset and mode inputs are unaffected.
- Join and handshake:
  - adv = m_tvalid & i_tvalid & (o_tready | !o_tvalid).
  - m_tready = i_tready = adv. Both streams advance together, one sample per adv cycle.
  - Each adv increments the sample index n (32 bits, wraps; only equality compares are used).
  - Each adv writes {data, metric, i_tlast} at n into the delay line. The delayed sample d = n - DELAY becomes available once the fill count reaches DELAY.
- Output register:
  - On adv with delayed sample d available and emit=1: o_tvalid=1 next cycle, carrying d's payload.
  - Otherwise, o_tready clears o_tvalid.
  - o_tdata and o_tlast are held stable while o_tvalid & !o_tready.
  - Latency: sample d appears one cycle after sample d+DELAY is accepted.
- Emit rule:
  - Mode 1: emit all samples; o_tdata=data, o_tlast=delayed i_tlast.
  - Mode 2: emit all samples; o_tdata=metric[METRIC_W-1 -: DATA_W], o_tlast=delayed i_tlast.
  - Mode 0/3: emit only in FORWARD; non-emitted samples are consumed and dropped.
  - The detection FSM runs in every mode.
- Detection FSM (evaluated on adv, on the current input metric):
  - IDLE: arms on any metric < threshold. If armed and metric >= threshold, go to SEARCH with max=metric, pk=n, win=1.
  - SEARCH: update max/pk only on a strictly greater metric, so ties keep the earliest index. When win reaches SEARCH_WIN:
    - pulse detect, set peak_value=max;
    - start = pk + offset, where offset is start_offset saturated to >= -(DELAY-SEARCH_WIN);
    - latch len = max(packet_length, 1);
    - go to ARMED and disarm.
  - ARMED: go to FORWARD when delayed index d == start (that sample is the first emitted).
  - FORWARD: count emitted samples. The sample with count == len gets o_tlast=1 in modes 0/3. Then frame_count += 1, go to IDLE.
  - Threshold crossings during SEARCH, ARMED or FORWARD are ignored.
  - Re-detection requires the metric to drop below threshold while in IDLE (hysteresis).
- threshold=0: the block never arms, so there is no detection.

Test Plan:
- Bench params DELAY=16, SEARCH_WIN=4; data = sample index.
- Detect: threshold=100, metric 0 except n40..43 = 150, 300, 200, 120; offset 0; len 8; mode 0 -> outputs 41..48, tlast on 48; one detect pulse; peak_value=300; frame_count=1.
- Offset: the same stimulus with offset -12 -> outputs 29..36. With offset -13 it saturates to -12, giving identical output.
- Hysteresis: metric 150 for n40..200, 0 at n201..209, 150 for n210..213 -> exactly two frames, starting at data 40 and 210; frame_count=2.
- Backpressure: the detect case with o_tready randomly 50% -> identical sequence 41..48, no drops or duplicates, o_tdata stable while stalled.
- Modes:
  - Mode 1 -> o_tdata 0,1,2,…, starting after the 17th input is accepted.
  - Mode 2 with metric 40'hABCDEF0123 -> o_tdata=32'hABCDEF01.
- Reset: reset_n low after 3 samples of FORWARD -> o_tvalid=0 asynchronously; after release, frame_count=0 and no output until 16 more samples are accepted.
